serial_frame_tx: RTL
====================

# serial_frame_tx

Parallel-to-serial frame transmitter that produces the single-bit data line consumed by the team's flop-based serial capture logic. It accepts a parallel word over a valid/ready handshake and shifts it out as a framed bit stream: start bit, data bits, optional even parity, stop bit. Each bit is held for a programmable number of clocks. It sits between a word-level producer and any single-wire serial sink in the design.

## Interface
Parameters:
- DATA_W, 8: data bits per frame, 1..32.
- CLKS_PER_BIT, 4: clock cycles each serial bit is held, ≥1.
- PARITY_EN, 1: 1 inserts an even-parity bit after the data bits; 0 omits it.
- LSB_FIRST, 1: 1 shifts in_data[0] first; 0 shifts in_data[DATA_W-1] first.

Ports:
- clk, input, 1: the single clock; all logic uses the rising edge.
- rst_n, input, 1: reset, asynchronous and active-low.
- in_valid, input, 1: producer presents a word.
- in_data, input, DATA_W: word to send; sampled only at the accept edge.
- in_ready, output, 1: block can accept a word (high only in IDLE).
- sout, output, 1: serial line, registered; idle level 1.
- busy, output, 1: a frame is in progress (state ≠ IDLE).
- done, output, 1: one-cycle pulse when a frame completes.

## Operation
- FSM states: IDLE, START, DATA, PARITY, STOP.
- IDLE: sout=1, in_ready=1, busy=0.
  - An accept occurs on a rising edge where in_valid && in_ready.
  - At the accept edge, load in_data into the shift register, compute parity = ^in_data, clear the bit-timer and bit-index, go to START.
- START: sout=0 for CLKS_PER_BIT cycles, then go to DATA.
- DATA: sout = current shift bit. The order follows LSB_FIRST.
  - Every CLKS_PER_BIT cycles, shift and increment the bit-index.
  - After DATA_W bits, go to PARITY if PARITY_EN, else STOP.
- PARITY: sout = XOR of all data bits (even parity) for CLKS_PER_BIT cycles, then go to STOP.
- STOP: sout=1 for CLKS_PER_BIT cycles, then go to IDLE and pulse done.
- Bit-timer: counts 0..CLKS_PER_BIT-1 and wraps. A state or bit advance happens only on the wrap.
  - Width is $clog2(CLKS_PER_BIT), minimum 1 bit.
- Bit-index width is $clog2(DATA_W+1).
- in_data and in_valid are ignored while busy. Changing in_data mid-frame has no effect on the frame.
- in_ready is a combinational decode of state==IDLE and does not depend on in_valid.
- Reset (rst_n=0, any time including mid-frame):
  - Immediately: state=IDLE, sout=1, done=0, busy=0, in_ready=1.
  - Shift register, timer and index are cleared.
  - The aborted frame is not resumed and produces no done.

## Timing
- Frame length F = (2 + DATA_W + PARITY_EN) × CLKS_PER_BIT cycles.
- The start bit appears on sout in the cycle after the accept edge.
- sout changes only on rising clk edges, or asynchronously to 1 on reset.
- done is high for exactly one cycle: the cycle after the last stop-bit cycle, i.e. F cycles after the accept edge.
  - In that same cycle, state=IDLE and in_ready=1.
- Back-to-back operation:
  - If in_valid is high during the done cycle, the next word is accepted at the end of that cycle.
  - The next start bit follows immediately, giving exactly one idle (sout=1) cycle between frames.
  - Sustained throughput is one word per F+1 cycles.
- CLKS_PER_BIT=1: one bit per clock. The timer logic is degenerate but legal.
- busy rises in the cycle after the accept edge and falls in the done cycle.

## Test plan
- Reset and idle:
  - Stimulus: hold rst_n=0 for 3 cycles, release, keep in_valid=0 for 20 cycles.
  - Required: sout=1, in_ready=1, busy=0, done=0 throughout.
- Single frame (DATA_W=8, CLKS_PER_BIT=4, PARITY_EN=1, LSB_FIRST=1), send 0xA5:
  - Required sout bit sequence, each bit held 4 cycles: 0 | 1,0,1,0,0,1,0,1 | 0 | 1.
  - Required: done pulses 44 cycles after the accept edge.
- Parity and order, send 0x07 with LSB_FIRST=0:
  - Required data bits: 0,0,0,0,0,1,1,1.
  - Required parity bit: 1.
  - Repeat with PARITY_EN=0: frame is 40 cycles and has no parity slot.
- Back-to-back, in_valid held high with words 0x3C then 0xC3:
  - Required: exactly one idle cycle between the two frames.
  - Required: second done at 89 cycles after the first accept edge.
  - Required: in_data changes during the first frame do not alter its bits.
- Reset mid-frame:
  - Stimulus: assert rst_n=0 during the 4th data bit, asynchronously between edges.
  - Required: sout=1 and in_ready=1 immediately, no done.
  - Required: a new word is accepted normally after release.
- CLKS_PER_BIT=1, send 0xFF:
  - Required: 11-cycle frame 0,1×8,0,1 with done at cycle 11.

Source files
------------

// File: rtl/serial_frame_tx.sv
// serial_frame_tx: parallel-to-serial frame transmitter.
// Frame = start(0) | DATA_W data bits | optional even parity | stop(1),
// each bit held CLKS_PER_BIT clocks. Word accepted over valid/ready in IDLE.
//
// state    | meaning
// ---------+-----------------------------------------------
// S_IDLE   | line idle (1), ready for a word
// S_START  | driving start bit (0)
// S_DATA   | driving data bits from the shift register
// S_PARITY | driving even parity of the accepted word
// S_STOP   | driving stop bit (1); done pulses on exit
module serial_frame_tx #(
  parameter int DATA_W       = 8,
  parameter int CLKS_PER_BIT = 4,
  parameter int PARITY_EN    = 1,
  parameter int LSB_FIRST    = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              sout,
  output logic              busy,
  output logic              done
);

  localparam int TW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int IW = $clog2(DATA_W + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  state_t            state_q, state_d;
  logic [TW-1:0]     tmr_q;
  logic [IW-1:0]     idx_q;
  logic [DATA_W-1:0] shreg_q, shreg_d;
  logic              par_q;
  logic              sout_q, sout_d;
  logic              done_q, done_d;
  logic              accept;
  logic              tmr_wrap;
  logic              last_bit;

  assign accept   = in_valid && (state_q == S_IDLE);
  assign tmr_wrap = (tmr_q == TW'(CLKS_PER_BIT - 1));
  assign last_bit = (idx_q == IW'(DATA_W - 1));

  // Next-state, next shift value, and next registered line level / done pulse.
  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    done_d  = 1'b0;
    sout_d  = 1'b1;
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          state_d = S_START;
          shreg_d = in_data;
        end
      end
      S_START: begin
        if (tmr_wrap) state_d = S_DATA;
      end
      S_DATA: begin
        if (tmr_wrap) begin
          shreg_d = (LSB_FIRST != 0) ? (shreg_q >> 1) : (shreg_q << 1);
          if (last_bit) state_d = (PARITY_EN != 0) ? S_PARITY : S_STOP;
        end
      end
      S_PARITY: begin
        if (tmr_wrap) state_d = S_STOP;
      end
      S_STOP: begin
        if (tmr_wrap) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
    // sout is registered, so it is derived from where the FSM is going next
    case (state_d)
      S_START:  sout_d = 1'b0;
      S_DATA:   sout_d = (LSB_FIRST != 0) ? shreg_d[0] : shreg_d[DATA_W-1];
      S_PARITY: sout_d = par_q;
      default:  sout_d = 1'b1;
    endcase
  end

  // State, line, done and shift-register update.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      shreg_q <= '0;
      sout_q  <= 1'b1;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      sout_q  <= sout_d;
      done_q  <= done_d;
    end
  end

  // Bit timer, bit index and parity capture.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tmr_q <= '0;
      idx_q <= '0;
      par_q <= 1'b0;
    end else begin
      if (state_q == S_IDLE || tmr_wrap) tmr_q <= '0;
      else                               tmr_q <= tmr_q + 1'b1;
      if (accept) begin
        idx_q <= '0;
        par_q <= ^in_data;
      end else if (state_q == S_DATA && tmr_wrap) begin
        idx_q <= idx_q + 1'b1;
      end
    end
  end

  assign in_ready = (state_q == S_IDLE);
  assign busy     = (state_q != S_IDLE);
  assign sout     = sout_q;
  assign done     = done_q;

endmodule
